mul_1_mant: RTL and testbench
=============================

Name: mul_1_mant

Overview:
- Mantissa multiplier for the FP multiply pipeline (stage 1 of mul_pipe2 datapath).
- Restores the hidden bit of each operand (1 for normal, 0 for subnormal) and forms the full unsigned product of the two (MANT_W+1)-bit significands.
- Result is registered; it feeds downstream normalisation/rounding together with the sign/exponent path computed in parallel.

Parameters:
- SIGN_W, default 1: sign width; interface compatibility only, unused.
- EXPO_W, default 8: exponent width; interface compatibility only, unused.
- MANT_W, default 23: stored mantissa width; MANT_W >= 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  inputs valid this cycle.
- a_is_sub  in  1  operand A is subnormal or zero; hidden bit = 0.
- b_is_sub  in  1  operand B is subnormal or zero; hidden bit = 0.
- a_mant  in  MANT_W  stored mantissa of A.
- b_mant  in  MANT_W  stored mantissa of B.
- out_valid  out  1  mant_1 holds the product of an accepted input.
- mant_1  out  2*MANT_W+2  unsigned product {~a_is_sub,a_mant} * {~b_is_sub,b_mant}.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Significands: sa = {~a_is_sub, a_mant} and sb = {~b_is_sub, b_mant}, each MANT_W+1 bits, unsigned.
- Product P = sa*sb is exact and MANT_W*2+2 bits wide; there is no truncation, rounding or sticky logic.
  - MSB (bit 2*MANT_W+1) set means a product in [2,4).
  - Bit 2*MANT_W set means a product in [1,2) for normal*normal.
- Implementation: partial-product generation, one row per bit of sb, each row gated by that bit and shifted. Rows are reduced with a carry-save (3:2 compressor) tree, followed by a final carry-propagate adder. A bare "*" operator is not acceptable. Combinational depth ends at the output register.
- Latency 1 cycle. When in_valid is sampled high at edge N, mant_1 = P and out_valid = 1 after edge N.
- When in_valid is low at an edge: out_valid drops to 0 and mant_1 holds its previous value.
- Throughput: one operation per cycle, no backpressure, no stall input.
- Reset: while rst is high at an edge, mant_1 is cleared to 0 and out_valid to 0. Reset overrides in_valid. An input presented in the same cycle as reset is discarded, and in-flight data is lost.
- After reset deasserts, the first accepted input appears on the following cycle.
- Flag cases:
  - a_is_sub=1 with a_mant=0 represents zero, giving P=0 regardless of B.
  - Both operands subnormal: P < 2^(2*MANT_W), so the top two bits are 0.
- Inputs X/undefined are not required to be handled.

Optional Feature:
- Macro MUL_1_MANT_PIPE2_EN.
- Defined:
  - A second register stage sits between the carry-save tree output (sum and carry vectors) and the final adder. The final adder result is registered.
  - Latency becomes 2 cycles; throughput stays 1/cycle.
  - out_valid is delayed by the same 2 stages.
  - Reset clears both stages, including the stage-1 valid.
- Undefined: the single-stage behaviour above, latency 1.

Test Plan (MANT_W=23):
- Normal 1.0*1.0: a_is_sub=b_is_sub=0, a_mant=b_mant=0, in_valid=1 -> next cycle mant_1=0x4000_0000_0000 (bit 46 set), out_valid=1.
- Max normals: a_mant=b_mant=0x7FFFFF, both normal -> mant_1=0xFFFF_FE00_0001.
- Subnormal*normal: a_is_sub=1, a_mant=0x000001; b_is_sub=0, b_mant=0 -> mant_1=0x0000_0080_0000. Zero operand (a_is_sub=1, a_mant=0) with any B -> mant_1=0.
- Back-to-back stream: operand pairs (0,0), (0x400000,0x400000), (0x7FFFFF,0) on consecutive cycles, all normal -> outputs 0x4000_0000_0000, 0x9000_0000_0000, 0x7FFF_FF80_0000 on consecutive cycles, out_valid held at 1. Then in_valid=0 -> out_valid=0 and mant_1 holds 0x7FFF_FF80_0000.
- Reset: assert rst for one cycle with in_valid=1 and operands 0x7FFFFF/0x7FFFFF -> mant_1=0 and out_valid=0 after that edge. The next valid input is produced normally one cycle after it is sampled.
- With MUL_1_MANT_PIPE2_EN: 1.0*1.0 input -> 0x4000_0000_0000 appears exactly 2 cycles later. A reset asserted between the two stages suppresses the output.

Source files
------------

// File: rtl/mul_1_mant.sv
// ============================================================================
//  Module      : mul_1_mant
//  Description : Mantissa multiplier, stage 1 of the FP multiply datapath.
//                Restores the hidden bit of each operand and forms the exact
//                unsigned product of the two (MANT_W+1)-bit significands.
//                Partial products are reduced by a 3:2 carry-save tree and
//                resolved by one carry-propagate adder feeding the output
//                register.
//  Ports       : clk, rst (sync, active-high)
//                in_valid, a_is_sub, b_is_sub, a_mant, b_mant  -> inputs
//                out_valid, mant_1 [2*MANT_W+1:0]              -> outputs
//  Options     : `define MUL_1_MANT_PIPE2_EN registers the carry-save
//                sum/carry vectors ahead of the final adder (latency 2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_1_mant #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                a_is_sub,
    input  logic                b_is_sub,
    input  logic [MANT_W-1:0]   a_mant,
    input  logic [MANT_W-1:0]   b_mant,
    output logic                out_valid,
    output logic [2*MANT_W+1:0] mant_1
);

    localparam int c_SIG_W  = MANT_W + 1;
    localparam int c_PROD_W = 2 * MANT_W + 2;

    // Rows remaining after `lvl` levels of 3:2 compression.
    function automatic int rows_after(input int rows, input int lvl);
        int r;
        r = rows;
        for (int i = 0; i < lvl; i++) begin
            r = (r / 3) * 2 + (r % 3);
        end
        return r;
    endfunction

    // Number of compression levels needed to reach two rows.
    function automatic int tree_depth(input int rows);
        int r;
        int d;
        r = rows;
        d = 0;
        while (r > 2) begin
            r = (r / 3) * 2 + (r % 3);
            d++;
        end
        return d;
    endfunction

    localparam int c_DEPTH = tree_depth(c_SIG_W);

    // SIGN_W / EXPO_W exist only so every stage of the multiply pipe shares
    // one parameter list; this empty block keeps them referenced.
    if (SIGN_W < 0 || EXPO_W < 0) begin : g_iface_only
    end

    // ------------------------------------------------------------------
    // Significands with restored hidden bit
    // ------------------------------------------------------------------
    logic [c_SIG_W-1:0]  w_sa;
    logic [c_SIG_W-1:0]  w_sb;
    logic [c_PROD_W-1:0] w_pp [c_SIG_W];
    logic [c_PROD_W-1:0] w_sum;
    logic [c_PROD_W-1:0] w_carry;

    assign w_sa = {~a_is_sub, a_mant};
    assign w_sb = {~b_is_sub, b_mant};

    // One partial-product row per multiplier bit
    for (genvar i = 0; i < c_SIG_W; i++) begin : g_pp
        assign w_pp[i] = w_sb[i] ? (c_PROD_W'(w_sa) << i) : '0;
    end

    // ------------------------------------------------------------------
    // Carry-save reduction tree. Each level compresses groups of three
    // rows into a sum and a (left-shifted) majority carry; leftover rows
    // pass straight through. Bits shifted beyond the product width are
    // always zero because the exact product fits in c_PROD_W bits.
    // ------------------------------------------------------------------
    for (genvar lv = 0; lv < c_DEPTH; lv++) begin : g_lvl
        localparam int c_RIN   = rows_after(c_SIG_W, lv);
        localparam int c_NCSA  = c_RIN / 3;
        localparam int c_NPASS = c_RIN % 3;
        localparam int c_ROUT  = 2 * c_NCSA + c_NPASS;

        logic [c_PROD_W-1:0] w_in  [c_RIN];
        logic [c_PROD_W-1:0] w_out [c_ROUT];

        for (genvar r = 0; r < c_RIN; r++) begin : g_src
            if (lv == 0) begin : g_from_pp
                assign w_in[r] = w_pp[r];
            end else begin : g_from_prev
                assign w_in[r] = g_lvl[lv-1].w_out[r];
            end
        end

        for (genvar k = 0; k < c_NCSA; k++) begin : g_csa
            assign w_out[2*k]   = w_in[3*k] ^ w_in[3*k+1] ^ w_in[3*k+2];
            assign w_out[2*k+1] = ((w_in[3*k]   & w_in[3*k+1]) |
                                   (w_in[3*k]   & w_in[3*k+2]) |
                                   (w_in[3*k+1] & w_in[3*k+2])) << 1;
        end

        for (genvar k = 0; k < c_NPASS; k++) begin : g_pass
            assign w_out[2*c_NCSA+k] = w_in[3*c_NCSA+k];
        end
    end

    assign w_sum   = g_lvl[c_DEPTH-1].w_out[0];
    assign w_carry = g_lvl[c_DEPTH-1].w_out[1];

    // ------------------------------------------------------------------
    // Output registers (final carry-propagate add sits just before them)
    // ------------------------------------------------------------------
    logic                r_out_valid;
    logic [c_PROD_W-1:0] r_mant;

`ifdef MUL_1_MANT_PIPE2_EN
    logic                r_v1;
    logic [c_PROD_W-1:0] r_sum;
    logic [c_PROD_W-1:0] r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_out_valid <= 1'b0;
            r_mant      <= '0;
        end else begin
            r_v1        <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_mant  <= r_sum + r_carry;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_mant      <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_mant  <= w_sum + w_carry;
            end
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign mant_1    = r_mant;

endmodule

`default_nettype wire

// File: tb/tb_mul_1_mant.sv
`default_nettype none

module tb_mul_1_mant;

    localparam int MW = 23;
    localparam int PW = 2 * MW + 2;
`ifdef MUL_1_MANT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          a_is_sub = 1'b0;
    logic          b_is_sub = 1'b0;
    logic [MW-1:0] a_mant = '0;
    logic [MW-1:0] b_mant = '0;
    logic          out_valid;
    logic [PW-1:0] mant_1;

    int n_tests = 0;
    int n_fail  = 0;

    mul_1_mant #(.SIGN_W(1), .EXPO_W(8), .MANT_W(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a_is_sub  (a_is_sub),
        .b_is_sub  (b_is_sub),
        .a_mant    (a_mant),
        .b_mant    (b_mant),
        .out_valid (out_valid),
        .mant_1    (mant_1)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight results in a delay line of LAT entries,
    // plus the last delivered product that the output holds.
    logic          line_v [LAT];
    logic [PW-1:0] line_p [LAT];
    logic          exp_v = 1'b0;
    logic [PW-1:0] exp_m = '0;

    function automatic logic [PW-1:0] ref_prod(input logic asub, input logic bsub,
                                               input logic [MW-1:0] am, input logic [MW-1:0] bm);
        longint unsigned sa, sb;
        sa = (asub ? 64'd0 : (64'd1 << MW)) + 64'(am);
        sb = (bsub ? 64'd0 : (64'd1 << MW)) + 64'(bm);
        return PW'(sa * sb);
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: update model at the edge, compare 1 time unit later.
    task automatic step(input string name);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                line_v[k] = 1'b0;
                line_p[k] = '0;
            end
            exp_v = 1'b0;
            exp_m = '0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                line_v[k] = line_v[k-1];
                line_p[k] = line_p[k-1];
            end
            line_v[0] = in_valid;
            line_p[0] = ref_prod(a_is_sub, b_is_sub, a_mant, b_mant);
            exp_v = line_v[LAT-1];
            if (exp_v) exp_m = line_p[LAT-1];
        end
        #1;
        check({name, "_valid"}, PW'(out_valid), PW'(exp_v));
        check({name, "_mant"}, mant_1, exp_m);
    endtask

    task automatic drive(input logic v, input logic asub, input logic bsub,
                         input logic [MW-1:0] am, input logic [MW-1:0] bm);
        in_valid = v;
        a_is_sub = asub;
        b_is_sub = bsub;
        a_mant   = am;
        b_mant   = bm;
    endtask

    typedef struct {
        string         name;
        logic          asub;
        logic          bsub;
        logic [MW-1:0] am;
        logic [MW-1:0] bm;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{"one_x_one",  1'b0, 1'b0, 23'h000000, 23'h000000, 48'h4000_0000_0000};
        vecs[1] = '{"max_norm",   1'b0, 1'b0, 23'h7FFFFF, 23'h7FFFFF, 48'hFFFF_FE00_0001};
        vecs[2] = '{"sub_x_norm", 1'b1, 1'b0, 23'h000001, 23'h000000, 48'h0000_0080_0000};
        vecs[3] = '{"zero_x_max", 1'b1, 1'b0, 23'h000000, 23'h7FFFFF, 48'h0000_0000_0000};
        vecs[4] = '{"max_x_zero", 1'b0, 1'b1, 23'h7FFFFF, 23'h000000, 48'h0000_0000_0000};
        vecs[5] = '{"sub_x_sub",  1'b1, 1'b1, 23'h7FFFFF, 23'h7FFFFF, 48'h0000_3FFF_FF00_0001 >> 0};
        vecs[6] = '{"1p5_sq",     1'b0, 1'b0, 23'h400000, 23'h400000, 48'h9000_0000_0000};

        for (int k = 0; k < LAT; k++) begin
            line_v[k] = 1'b0;
            line_p[k] = '0;
        end

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].asub, vecs[i].bsub, vecs[i].am, vecs[i].bm);
            step(vecs[i].name);
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            for (int j = 1; j < LAT; j++) step(vecs[i].name);
            check({vecs[i].name, "_tbl_valid"}, PW'(out_valid), PW'(1));
            check({vecs[i].name, "_tbl_mant"}, mant_1, vecs[i].exp);
        end

        // Back-to-back stream, then idle hold
        drive(1'b1, 1'b0, 1'b0, 23'h000000, 23'h000000); step("s0");
        drive(1'b1, 1'b0, 1'b0, 23'h400000, 23'h400000); step("s1");
        drive(1'b1, 1'b0, 1'b0, 23'h7FFFFF, 23'h000000); step("s2");
        drive(1'b0, 1'b0, 1'b0, 23'h123456, 23'h654321);
        for (int j = 1; j < LAT; j++) step("s_drain");
        check("stream_last", mant_1, 48'h7FFF_FF80_0000);
        step("idle");
        check("idle_valid", PW'(out_valid), PW'(0));
        check("idle_hold", mant_1, 48'h7FFF_FF80_0000);

        // Reset overrides a valid input
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 23'h7FFFFF, 23'h7FFFFF);
        step("rst_ovr");
        check("rst_ovr_mant", mant_1, '0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 23'h000000, 23'h000000);
        step("post_rst");
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int j = 1; j < LAT; j++) step("post_rst_d");
        check("post_rst_mant", mant_1, 48'h4000_0000_0000);

        // Reset landing while an operation is in flight
        drive(1'b1, 1'b0, 1'b0, 23'h7FFFFF, 23'h7FFFFF);
        step("mid_a");
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step("mid_rst");
        rst = 1'b0;
        step("mid_after");
        check("mid_after_valid", PW'(out_valid), PW'(0));
        check("mid_after_mant", mant_1, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  MW'($urandom), MW'($urandom));
            step("rand");
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int j = 0; j < LAT; j++) step("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
